reg_load_arbiter: RTL and testbench

- Round-robin arbiter and load sequencer for one shared WIDTH-bit load-enabled register.
- Sits between NUM_REQ requesters and the register's ld/regin inputs.
- Grants one requester at a time, captures its data, pulses the register load for one cycle, then acknowledges the winner.
- Keeps a running count of completed loads for debug and performance monitoring.

---
 rtl/reg_load_arbiter.sv | 121 ++++++++++++
 tb/tb_reg_load_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter and load sequencer for one shared load-enabled register.
// Each transaction runs IDLE -> LOAD -> ACK. Data is captured when the grant is
// issued, the register load is pulsed for one cycle, and then the winner gets a
// one-cycle ack. The pointer rotates past the winner so that every requester is
// served in turn.
module reg_load_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16,
    localparam int OW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     reg_ld,
    output logic [WIDTH-1:0]         reg_in,
    output logic                     busy,
    output logic [OW-1:0]            owner,
    output logic [CNT_WIDTH-1:0]     load_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

    state_t               state_q, state_d;
    logic [OW-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_d, ack_d;
    logic                 reg_ld_d;
    logic [WIDTH-1:0]     reg_in_d;
    logic [OW-1:0]        owner_d;
    logic [CNT_WIDTH-1:0] load_cnt_d;

    logic                 win_found;
    logic [OW-1:0]        win_idx;

    // Rotating search from ptr with explicit wrap. NUM_REQ need not be a power of 2.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = OW'(idx);
            end
        end
    end

    // Next-state and next-output logic. Every output is registered.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt;
        ack_d      = ack;
        reg_ld_d   = reg_ld;
        reg_in_d   = reg_in;
        owner_d    = owner;
        load_cnt_d = load_cnt;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d        = LOAD;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    reg_in_d       = req_data[win_idx*WIDTH +: WIDTH];
                    reg_ld_d       = 1'b1;
                end
            end
            LOAD: begin
                // The counter wraps naturally from all-ones to zero.
                state_d    = ACK;
                reg_ld_d   = 1'b0;
                ack_d      = gnt;
                load_cnt_d = load_cnt + 1'b1;
            end
            ACK: begin
                state_d = IDLE;
                gnt_d   = '0;
                ack_d   = '0;
                ptr_d   = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                ack_d    = '0;
                reg_ld_d = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt      <= '0;
            ack      <= '0;
            reg_ld   <= 1'b0;
            reg_in   <= '0;
            owner    <= '0;
            load_cnt <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt      <= gnt_d;
            ack      <= ack_d;
            reg_ld   <= reg_ld_d;
            reg_in   <= reg_in_d;
            owner    <= owner_d;
            load_cnt <= load_cnt_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed bench for reg_load_arbiter. The main instance has 4 requesters and a
// 16-bit counter. The second instance has a 4-bit counter for the wrap test.
module tb_reg_load_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req, req2;
    logic [63:0] req_data, req_data2;
    logic [3:0]  gnt, ack, gnt2, ack2;
    logic        reg_ld, reg_ld2;
    logic [15:0] reg_in, reg_in2;
    logic        busy, busy2;
    logic [1:0]  owner, owner2;
    logic [15:0] load_cnt;
    logic [3:0]  load_cnt2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    reg_load_arbiter #(.NUM_REQ(4), .WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .ack(ack), .reg_ld(reg_ld), .reg_in(reg_in),
        .busy(busy), .owner(owner), .load_cnt(load_cnt)
    );

    reg_load_arbiter #(.NUM_REQ(4), .WIDTH(16), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .reset(reset), .req(req2), .req_data(req_data2),
        .gnt(gnt2), .ack(ack2), .reg_ld(reg_ld2), .reg_in(reg_in2),
        .busy(busy2), .owner(owner2), .load_cnt(load_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rising edges so that the spacing between loads can be measured.
    always @(posedge clk) cyc <= cyc + 1;

    // Structural invariants, checked on every falling edge while out of reset.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            if (((gnt & (gnt - 4'd1)) !== 4'd0) || ((ack !== 4'd0) && (ack !== gnt)) ||
                (reg_ld && (ack !== 4'd0))) begin
                errors++;
                $display("FAIL invariant: gnt=%b ack=%b reg_ld=%b at t=%0t", gnt, ack, reg_ld, $time);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0; req = '0; req2 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Waits for reg_ld on the main instance, with a bound on the number of cycles.
    task automatic wait_ld(output int at_cyc);
        int n;
        n = 0;
        while (reg_ld !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        at_cyc = cyc;
        if (reg_ld !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wait_ld: no reg_ld within 20 cycles");
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req = '0; req2 = '0; req_data = '0; req_data2 = '0;
        #1;
        checks++;
        if ({gnt, ack, reg_ld, reg_in, busy, owner, load_cnt} !== '0 || load_cnt2 !== 4'd0) begin
            errors++;
            $display("FAIL reset_async: gnt=%b ack=%b ld=%b in=%h busy=%b own=%0d cnt=%0d", gnt, ack, reg_ld, reg_in, busy, owner, load_cnt);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt, ack, reg_ld, busy, load_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_idle: gnt=%b ack=%b ld=%b busy=%b cnt=%0d expected all 0", gnt, ack, reg_ld, busy, load_cnt);
        end
    endtask

    task automatic test_single();
        req = 4'b0001; req_data[15:0] = 16'hA5A5;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || reg_ld !== 1'b1 || reg_in !== 16'hA5A5 || busy !== 1'b1 || ack !== 4'd0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL single_load: gnt=%b ld=%b in=%h busy=%b ack=%b own=%0d expected 0001 1 a5a5 1 0000 0", gnt, reg_ld, reg_in, busy, ack, owner);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || reg_ld !== 1'b0 || ack !== 4'b0001 || load_cnt !== 16'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_ack: gnt=%b ld=%b ack=%b cnt=%0d busy=%b expected 0001 0 0001 1 1", gnt, reg_ld, ack, load_cnt, busy);
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (gnt !== 4'd0 || ack !== 4'd0 || busy !== 1'b0 || load_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_idle: gnt=%b ack=%b busy=%b cnt=%0d expected 0000 0000 0 1", gnt, ack, busy, load_cnt);
        end
    endtask

    task automatic test_all_req();
        int t, t_prev;
        do_reset();
        for (int i = 0; i < 4; i++) req_data[16*i +: 16] = 16'h1000 + 16'(i);
        req = 4'b1111;
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ld(t);
            checks++;
            if (gnt !== (4'b0001 << i) || owner !== 2'(i) || reg_in !== 16'h1000 + 16'(i)) begin
                errors++;
                $display("FAIL all_grant%0d: gnt=%b own=%0d in=%h expected one-hot %0d", i, gnt, owner, reg_in, i);
            end
            if (i > 0) begin
                checks++;
                if (t - t_prev != 3) begin
                    errors++;
                    $display("FAIL all_spacing%0d: got %0d cycles expected 3", i, t - t_prev);
                end
            end
            t_prev = t;
            @(negedge clk);
            checks++;
            if (ack !== (4'b0001 << i)) begin
                errors++;
                $display("FAIL all_ack%0d: ack=%b expected bit %0d", i, ack, i);
            end
            req[i] = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (load_cnt !== 16'd4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL all_count: cnt=%0d busy=%b expected 4 0", load_cnt, busy);
        end
        // With the pointer back at 0, requester 0 beats requester 3.
        req = 4'b1001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL all_ptr_wrap: gnt=%b expected 0001", gnt);
        end
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int t, exp;
        do_reset();
        req = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            wait_ld(t);
            exp = (k % 2 == 0) ? 0 : 2;
            checks++;
            if (owner !== 2'(exp) || gnt !== (4'b0001 << exp)) begin
                errors++;
                $display("FAIL fair_%0d: own=%0d gnt=%b expected %0d", k, owner, gnt, exp);
            end
            @(negedge clk);
            if (k == 5) req = 4'b0000;
        end
        @(negedge clk);
    endtask

    task automatic test_data_change();
        int t;
        req = 4'b0010; req_data[31:16] = 16'h1234;
        wait_ld(t);
        req_data[31:16] = 16'hFFFF;
        #1;
        checks++;
        if (reg_ld !== 1'b1 || gnt !== 4'b0010 || reg_in !== 16'h1234) begin
            errors++;
            $display("FAIL data_load: ld=%b gnt=%b in=%h expected 1 0010 1234", reg_ld, gnt, reg_in);
        end
        @(negedge clk);
        checks++;
        if (ack !== 4'b0010 || reg_in !== 16'h1234) begin
            errors++;
            $display("FAIL data_ack: ack=%b in=%h expected 0010 1234", ack, reg_in);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_in_load();
        int t;
        // The pointer is at 2 here, so an unreset pointer would pick 3 over 1 below.
        req = 4'b0100; req_data[47:32] = 16'h5555;
        wait_ld(t);
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL rst_pre: gnt=%b expected 0100", gnt);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (reg_ld !== 1'b0 || gnt !== 4'd0 || busy !== 1'b0 || load_cnt !== 16'd0 || ack !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid: ld=%b gnt=%b busy=%b cnt=%0d ack=%b expected all 0", reg_ld, gnt, busy, load_cnt, ack);
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_noack: ack=%b busy=%b expected 0000 0", ack, busy);
        end
        req = 4'b1010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL rst_ptr0: gnt=%b expected 0010", gnt);
        end
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_counter_wrap();
        do_reset();
        req_data2 = '0;
        for (int t = 1; t <= 17; t++) begin
            req2 = 4'b0001;
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (ack2 !== 4'b0001 || load_cnt2 !== 4'(t % 16)) begin
                errors++;
                $display("FAIL wrap_%0d: ack=%b cnt=%0d expected 0001 %0d", t, ack2, load_cnt2, t % 16);
            end
            req2 = 4'b0000;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_req();
        test_fairness();
        test_data_change();
        test_reset_in_load();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
